// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: STEP bits per clock, LSB first, with the
// carry/borrow held in a flop between steps; result, cout and ovf are latched on entry to DONE.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [STEP-1:0]  step_sum;
  logic [STEP:0]    chain;
  logic [WIDTH-1:0] acc_shift;
  logic             last_step;
  logic             res_msb;

  // Ripple chain across the STEP bits currently at the bottom of the operand shifters.
  assign chain[0] = carry_q;

  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_bit
      logic x_bit, y_bit;
      assign x_bit        = a_q[gi];
      assign y_bit        = b_q[gi];
      assign step_sum[gi] = x_bit ^ y_bit ^ chain[gi];
      assign chain[gi+1]  = mode_q ? ((~x_bit & y_bit) | (~(x_bit ^ y_bit) & chain[gi]))
                                   : ((x_bit & y_bit) | ((x_bit ^ y_bit) & chain[gi]));
    end
  endgenerate

  // New step bits enter at the top so the accumulator is fully aligned after N steps.
  assign acc_shift = (acc_q >> STEP) | (WIDTH'(step_sum) << (WIDTH - STEP));
  assign last_step = (cnt_q == CW'(N - 1));
  assign res_msb   = acc_shift[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
        end
      end
      RUN: begin
        a_d     = a_q >> STEP;
        b_d     = b_q >> STEP;
        acc_d   = acc_shift;
        carry_d = chain[STEP];
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = acc_shift;
          cout_d   = chain[STEP];
          ovf_d    = (mode_q ? (a_msb_q != b_msb_q) : (a_msb_q == b_msb_q))
                     && (res_msb != a_msb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>= 2).
REQ-002 SHALL have parameter STEP, default 1, bits processed per clock (must divide WIDTH; N = WIDTH/STEP steps).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-007 SHALL have port a  input  WIDTH  minuend/augend; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  subtrahend/addend; sampled with start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-011 SHALL have port result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  add: carry out of MSB; sub: borrow out of MSB (1 when a < b unsigned).
REQ-013 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 at an edge SHALL capture a, b, mode, clear the step counter and carry/borrow (initial value 0), and enter RUN. start=0 keeps IDLE.
REQ-016 RUN SHALL process STEP bits per edge, LSB-first, in ripple order within the step.
REQ-016a Per-bit sub: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
REQ-016b Per-bit add: s = x^y^cin; cout = (x&y) | ((x^y)&cin).
REQ-017 The carry/borrow SHALL be registered between steps; after step N, RUN SHALL enter DONE.
REQ-018 With start accepted at edge E, busy SHALL be 1 after edges E..E+N-1, and done SHALL be 1 and busy 0 only after edge E+N (latency N cycles).
REQ-019 DONE SHALL last exactly one cycle; start=1 in DONE SHALL be accepted as in IDLE (back-to-back), otherwise return to IDLE.
REQ-020 start SHALL be ignored while in RUN; captured operands and mode SHALL NOT change mid-operation.
REQ-021 result, cout and ovf SHALL be updated only on the transition into DONE and held stable until the next transition into DONE or reset.
REQ-022 ovf rule:
- add: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
- sub: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
REQ-023 Changes on a, b, or mode while not starting SHALL have no effect.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, with busy=0, done=0, result=0, cout=0, ovf=0, and clear the counter and carry; rst SHALL take priority over start.
REQ-025 rst during RUN SHALL abort the operation with no done pulse; the first start after rst is released SHALL operate normally.

Verification (WIDTH=8, STEP=1 unless stated)
REQ-026 mode=1, a=0x05, b=0x03 -> done exactly 8 cycles after start edge; result=0x02, cout=0, ovf=0.
REQ-027 mode=1:
- a=0x03, b=0x05 -> result=0xFE, cout=1, ovf=0.
- a=0x80, b=0x01 -> result=0x7F, cout=0, ovf=1.
REQ-028 mode=0:
- a=0xFF, b=0x01 -> result=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01 -> result=0x80, cout=0, ovf=1.
REQ-029 start held high during RUN with new operands -> ignored, original result delivered. start high in DONE cycle -> second operation begins, done again 8 cycles later.
REQ-030 rst asserted after 3 RUN steps -> next cycle busy=0, done=0, result=0; no done pulse appears.
REQ-031 STEP=4, mode=1, a=0x10, b=0x01 -> done 2 cycles after start; result=0x0F, cout=0, ovf=0. Random sweep of both modes vs a reference model, all STEP values.
